// File: rtl/sng_pkg.sv
// Shared types and constants for the multi-channel stochastic number generator.
// Holds the FSM state type, stream length helper and maximal-length LFSR tap table.
package sng_pkg;

    typedef enum logic {S_IDLE, S_RUN} sng_state_e;

    // Stream length L = 2^w - 1, one beat per non-zero LFSR state
    function automatic int unsigned stream_len(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Fibonacci XOR tap masks (bit k-1 set for tap k), maximal length for w = 3..16
    function automatic logic [15:0] lfsr_taps(input int unsigned w);
        logic [15:0] taps;
        case (w)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/sng_multi_lfsr.sv
// One Fibonacci maximal-length LFSR lane with synchronous seed load and step enable.
// Exposes the state the lane would hold after one step, so the owner can register its comparison.
module sng_lfsr
    import sng_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] seed_i,
    input  logic         en_i,
    output logic [W-1:0] next_c_o
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q, state_d;
    logic         fb;

    assign fb       = ^(state_q & TAPS);
    assign next_c_o = {state_q[W-2:0], fb};

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = next_c_o;
        end
    end

    // Reset to a non-zero value so the lane never parks in the lock-up state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= W'(1);
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sng_multi.sv
// Multi-channel unipolar SNG: each channel emits 2^W-1 beats holding exactly x ones,
// with shared framing FSM, back-pressure, last/done signalling and a correlated mode.
module sng_multi
    import sng_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter int unsigned N_CH = 8
) (
    input  logic              i_clk_sngm,
    input  logic              i_rst_sngm,
    input  logic [N_CH*W-1:0] i_x_sngm,
    input  logic              i_corr_sngm,
    input  logic              i_start_sngm,
    input  logic              i_stop_sngm,
    input  logic              i_ready_sngm,
    output logic [N_CH-1:0]   o_sn_sngm,
    output logic              o_valid_sngm,
    output logic              o_last_sngm,
    output logic              o_busy_sngm,
    output logic              o_done_sngm
);

    localparam int unsigned  L        = stream_len(W);
    localparam logic [W-1:0] LAST_CNT = W'(L);

    sng_state_e        state_q, state_d;
    logic [W-1:0]      cnt_q, cnt_d;
    logic              corr_q, corr_d;
    logic [N_CH-1:0]   sn_q, sn_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load, adv, clr, accept;
    logic [W-1:0]      nxt [N_CH];

    assign accept = valid_q & i_ready_sngm;

    // Framing FSM and shared beat counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        corr_d  = corr_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        adv     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start_sngm && !i_stop_sngm) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                    cnt_d   = W'(1);
                    corr_d  = i_corr_sngm;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (i_stop_sngm) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    clr     = 1'b1;
                end else if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        clr     = 1'b1;
                    end else begin
                        adv    = 1'b1;
                        cnt_d  = cnt_q + W'(1);
                        last_d = ((cnt_q + W'(1)) == LAST_CNT);
                    end
                end
            end
        endcase
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [W-1:0] seed;
        logic [W-1:0] x_in;
        logic [W-1:0] x_q, x_d;
        logic [W-1:0] rnd_adv;

        assign x_in = i_x_sngm[c*W +: W];
        assign seed = i_corr_sngm ? W'(1) : W'(c + 1);
        assign x_d  = load ? x_in : x_q;

        sng_lfsr #(.W(W)) u_lfsr (
            .clk_i    (i_clk_sngm),
            .rst_i    (i_rst_sngm),
            .load_i   (load),
            .seed_i   (seed),
            .en_i     (adv),
            .next_c_o (nxt[c])
        );

        // Correlated mode: every channel compares against lane 0
        if (c == 0) begin : g_sel0
            assign rnd_adv = nxt[0];
        end else begin : g_seln
            assign rnd_adv = corr_q ? nxt[0] : nxt[c];
        end

        assign sn_d[c] = load ? (seed <= x_in)
                       : adv  ? (rnd_adv <= x_q)
                       : clr  ? 1'b0
                       : sn_q[c];

        always_ff @(posedge i_clk_sngm or posedge i_rst_sngm) begin
            if (i_rst_sngm) begin
                x_q <= '0;
            end else begin
                x_q <= x_d;
            end
        end
    end

    always_ff @(posedge i_clk_sngm or posedge i_rst_sngm) begin
        if (i_rst_sngm) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            corr_q  <= 1'b0;
            sn_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            corr_q  <= corr_d;
            sn_q    <= sn_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_sn_sngm    = sn_q;
    assign o_valid_sngm = valid_q;
    assign o_last_sngm  = last_q;
    assign o_busy_sngm  = busy_q;
    assign o_done_sngm  = done_q;

endmodule

// File: tb/tb_sng_multi.sv
// Scoreboard bench for sng_multi (W=4, N_CH=8): stimulus pushes expected per-stream
// results, a negedge monitor accumulates accepted beats and checks them at done.
module tb_sng_multi;

    localparam int unsigned W    = 4;
    localparam int unsigned N_CH = 8;
    localparam int          L    = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] x;
    logic        corr, start, stop, ready;
    logic [7:0]  sn;
    logic        valid, last, busy, done;

    always #5 clk = ~clk;

    sng_multi #(.W(W), .N_CH(N_CH)) dut (
        .i_clk_sngm   (clk),
        .i_rst_sngm   (rst),
        .i_x_sngm     (x),
        .i_corr_sngm  (corr),
        .i_start_sngm (start),
        .i_stop_sngm  (stop),
        .i_ready_sngm (ready),
        .o_sn_sngm    (sn),
        .o_valid_sngm (valid),
        .o_last_sngm  (last),
        .o_busy_sngm  (busy),
        .o_done_sngm  (done)
    );

    typedef struct packed {
        logic [7:0][4:0] cnt;
        logic            chk_pair;
        logic [4:0]      and_exp;
        logic [4:0]      or_exp;
        logic            chk_first;
        logic [7:0]      b1;
        logic [7:0]      b2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Each channel of a full stream carries exactly x ones
    function automatic exp_t mk(input logic [31:0] xv);
        exp_t e;
        e = '0;
        for (int c = 0; c < 8; c++) e.cnt[c] = 5'(xv[c*4 +: 4]);
        return e;
    endfunction

    // Monitor
    int          acc [8];
    int          beats, and_c, or_c;
    logic [7:0]  p_sn;
    logic        p_valid, p_last, p_ready;
    exp_t        mon_e;

    task automatic clear_acc();
        for (int c = 0; c < 8; c++) acc[c] = 0;
        beats = 0; and_c = 0; or_c = 0;
    endtask

    initial begin
        clear_acc();
        p_sn = '0; p_valid = 1'b0; p_last = 1'b0; p_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            clear_acc();
            p_valid = 1'b0;
            p_ready = 1'b1;
        end else begin
            if (p_valid && !p_ready) begin
                chk("hold_sn", int'(sn), int'(p_sn));
                chk("hold_valid", int'(valid), 1);
                chk("hold_last", int'(last), int'(p_last));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    for (int c = 0; c < 8; c++) chk($sformatf("ones_ch%0d", c), acc[c], int'(mon_e.cnt[c]));
                    chk("beat_count", beats, L);
                    if (mon_e.chk_pair) begin
                        chk("corr_and", and_c, int'(mon_e.and_exp));
                        chk("corr_or", or_c, int'(mon_e.or_exp));
                    end
                end
                clear_acc();
            end else if (p_valid && !valid) begin
                clear_acc();
            end
            if (valid && ready) begin
                beats++;
                for (int c = 0; c < 8; c++) acc[c] += int'(sn[c]);
                and_c += int'(sn[0] & sn[1]);
                or_c  += int'(sn[0] | sn[1]);
                chk("last_flag", int'(last), int'(beats == L));
                if (exp_q.size() > 0 && exp_q[0].chk_first) begin
                    if (beats == 1) chk("beat1_bits", int'(sn), int'(exp_q[0].b1));
                    if (beats == 2) chk("beat2_bits", int'(sn), int'(exp_q[0].b2));
                end
            end
            p_sn = sn; p_valid = valid; p_last = last; p_ready = ready;
        end
    end

    // Stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [31:0] xv, input logic cv, input bit push, input exp_t e);
        x = xv; corr = cv; start = 1'b1;
        if (push) exp_q.push_back(e);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        n = 0;
        while (!done && n < 400) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        ready = 1'b1;
        chk("stream_done", int'(done), 1);
    endtask

    localparam logic [31:0] XS = 32'hECA8_6420;   // x_c = 2c
    exp_t e1, e3;

    initial begin
        rst = 1'b0; x = '0; corr = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_sn", int'(sn), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_last", int'(last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        step(); step();
        rst = 1'b0;
        step();

        // Decorrelated x_c = 2c; beat 1 rnd_c = c+1, beat 2 rnd = {2,4,6,9,11,13,15,1}
        e1 = mk(XS); e1.chk_first = 1'b1; e1.b1 = 8'hFE; e1.b2 = 8'h80;
        start_stream(XS, 1'b0, 1'b1, e1);
        chk("s1_busy", int'(busy), 1);
        wait_done(1'b0);
        chk("s1_busy_at_done", int'(busy), 0);
        chk("s1_valid_at_done", int'(valid), 0);
        step();
        chk("s1_done_one_cycle", int'(done), 0);
        chk("s1_busy_after", int'(busy), 0);

        // All-zero stream, then all-one stream started in the done cycle
        start_stream(32'h0, 1'b0, 1'b1, mk(32'h0));
        wait_done(1'b0);
        start_stream(32'hFFFF_FFFF, 1'b0, 1'b1, mk(32'hFFFF_FFFF));
        chk("b2b_valid", int'(valid), 1);
        chk("b2b_done_low", int'(done), 0);
        wait_done(1'b0);
        step();

        // Correlated: stream0 (x=5) is a subset of stream1 (x=9)
        e3 = mk(32'hA987_6595); e3.chk_pair = 1'b1; e3.and_exp = 5'd5; e3.or_exp = 5'd9;
        start_stream(32'hA987_6595, 1'b1, 1'b1, e3);
        wait_done(1'b0);
        step();

        // Random back-pressure
        start_stream(XS, 1'b0, 1'b1, e1);
        wait_done(1'b1);
        step();

        // Stop on beat 6, then a fresh full stream
        start_stream(XS, 1'b0, 1'b0, e1);
        repeat (5) step();
        chk("s5_valid_beat6", int'(valid), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_valid", int'(valid), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_done", int'(done), 0);
        step();
        chk("stop_no_late_done", int'(done), 0);
        start_stream(XS, 1'b0, 1'b1, e1);
        wait_done(1'b0);
        step();

        // Start re-pulsed on beat 3 with new operands: ignored
        start_stream(XS, 1'b0, 1'b1, e1);
        repeat (2) step();
        x = 32'hFFFF_FFFF; start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", int'(busy), 1);
        wait_done(1'b0);
        step();

        // Reset on beat 8 clears outputs before the next edge
        start_stream(XS, 1'b0, 1'b0, e1);
        repeat (7) step();
        chk("s6_valid_beat8", int'(valid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_sn", int'(sn), 0);
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_last", int'(last), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        step();
        rst = 1'b0;
        step();
        start_stream(XS, 1'b0, 1'b1, e1);
        wait_done(1'b0);
        step();
        step();

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
